// File: rtl/gate_bist_if.sv
// Operand/result bundle between the gate BIST engine (master) and the gate under test (slave).
interface gate_bist_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] stim_a;
    logic [WIDTH-1:0] stim_b;
    logic [WIDTH-1:0] dut_x;

    modport master (output stim_a, output stim_b, input dut_x);
    modport slave  (input stim_a, input stim_b, output dut_x);
endinterface

// File: rtl/gate_bist.sv
// Purpose: LFSR-driven stimulus and checker for a WIDTH-bit two-input logic gate.
// Latency: vector k is issued in cycle k+1 after start and checked LATENCY cycles later.
// Backpressure: none; one vector per clock, start is ignored while a run is in flight.
module gate_bist #(
    parameter int          WIDTH       = 1,
    parameter int          NUM_VECTORS = 20,
    parameter int          LATENCY     = 0,
    parameter logic [31:0] SEED        = 32'hACE1_0001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op_sel,
    gate_bist_if.master        gif,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [19:0]        vec_count,
    output logic [19:0]        first_fail_idx
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [1:0]  ST_DONE  = 2'd3;

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] FB_MASK  = 32'h8020_0003;
    localparam logic [19:0] LAST_IDX = 20'(NUM_VECTORS - 1);

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_nxt;
    logic [19:0]      issue_idx;
    logic [WIDTH-1:0] stim_a_q;
    logic [WIDTH-1:0] stim_b_q;
    logic [WIDTH-1:0] exp_now;
    logic             vld_now;
    logic [WIDTH-1:0] cmp_exp;
    logic             cmp_vld;
    logic             start_ok;
    logic             last_issue;
    logic             last_cmp;
    logic             mismatch;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? FB_MASK : 32'h0);
    endfunction

    function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return a;
            default: return ~a;
        endcase
    endfunction

    assign lfsr_nxt   = lfsr_step(lfsr);
    assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_issue = (state == ST_RUN) && (issue_idx == LAST_IDX);
    assign last_cmp   = cmp_vld && (vec_count == LAST_IDX);
    assign mismatch   = cmp_vld && (gif.dut_x != cmp_exp);

    // lfsr always holds the vector currently visible on stim_a/stim_b
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= 3'd0;
            lfsr      <= SEED_EFF;
            issue_idx <= 20'd0;
            stim_a_q  <= '0;
            stim_b_q  <= '0;
        end else if (start_ok) begin
            state     <= ST_RUN;
            op_q      <= op_sel;
            lfsr      <= SEED_EFF;
            issue_idx <= 20'd0;
            stim_a_q  <= SEED_EFF[WIDTH-1:0];
            stim_b_q  <= SEED_EFF[16 +: WIDTH];
        end else begin
            case (state)
                ST_RUN: begin
                    if (last_issue) begin
                        stim_a_q <= '0;
                        stim_b_q <= '0;
                        state    <= (LATENCY == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        lfsr      <= lfsr_nxt;
                        issue_idx <= issue_idx + 20'd1;
                        stim_a_q  <= lfsr_nxt[WIDTH-1:0];
                        stim_b_q  <= lfsr_nxt[16 +: WIDTH];
                    end
                end
                ST_DRAIN: begin
                    if (last_cmp) state <= ST_DONE;
                end
                default: ;
            endcase
        end
    end

    assign exp_now = gate_fn(op_q, stim_a_q, stim_b_q);
    assign vld_now = (state == ST_RUN);

    generate
        if (LATENCY == 0) begin : g_direct
            assign cmp_exp = exp_now;
            assign cmp_vld = vld_now;
        end else begin : g_pipe
            logic [WIDTH-1:0] exp_pipe [LATENCY];
            logic             vld_pipe [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        exp_pipe[i] <= '0;
                        vld_pipe[i] <= 1'b0;
                    end
                end else begin
                    exp_pipe[0] <= exp_now;
                    vld_pipe[0] <= vld_now;
                    for (int i = 1; i < LATENCY; i++) begin
                        exp_pipe[i] <= exp_pipe[i-1];
                        vld_pipe[i] <= vld_pipe[i-1];
                    end
                end
            end

            assign cmp_exp = exp_pipe[LATENCY-1];
            assign cmp_vld = vld_pipe[LATENCY-1];
        end
    endgenerate

    // compares arrive in issue order, so vec_count is the index of the vector being checked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= 16'd0;
            vec_count      <= 20'd0;
            first_fail_idx <= 20'd0;
        end else if (start_ok) begin
            err_count      <= 16'd0;
            vec_count      <= 20'd0;
            first_fail_idx <= 20'd0;
        end else if (cmp_vld) begin
            vec_count <= vec_count + 20'd1;
            if (mismatch) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'd0)    first_fail_idx <= vec_count;
            end
        end
    end

    assign gif.stim_a = stim_a_q;
    assign gif.stim_b = stim_b_q;
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign pass       = done && (err_count == 16'd0);

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: four builds with bench-side gate models, a vector table, a scoreboard and reset/start corner cases.
module tb_gate_bist;

    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam int M_NAND = 0, M_XOR1 = 1, M_REG2 = 2, M_XNOR = 3, M_TIEF = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start_s;
    logic [2:0]  op_s [4];
    wire  [3:0]  busy_w, done_w, pass_w;
    wire  [15:0] err_w [4];
    wire  [19:0] vec_w [4];
    wire  [19:0] ff_w  [4];
    wire  [7:0]  sa [4];
    wire  [7:0]  sb [4];
    int          u1_mode = M_XOR1;
    logic [7:0]  r1_1 = 8'h0, r2_1 = 8'h0, r1_2 = 8'h0, r2_2 = 8'h0;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    gate_bist_if #(.WIDTH(1)) bif0 ();
    gate_bist_if #(.WIDTH(8)) bif1 ();
    gate_bist_if #(.WIDTH(8)) bif2 ();
    gate_bist_if #(.WIDTH(4)) bif3 ();

    gate_bist #(.WIDTH(1), .NUM_VECTORS(20), .LATENCY(0), .SEED(SEED)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op_sel(op_s[0]), .gif(bif0.master),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .vec_count(vec_w[0]), .first_fail_idx(ff_w[0]));
    gate_bist #(.WIDTH(8), .NUM_VECTORS(20), .LATENCY(0), .SEED(SEED)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op_sel(op_s[1]), .gif(bif1.master),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .vec_count(vec_w[1]), .first_fail_idx(ff_w[1]));
    gate_bist #(.WIDTH(8), .NUM_VECTORS(20), .LATENCY(2), .SEED(SEED)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .op_sel(op_s[2]), .gif(bif2.master),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .vec_count(vec_w[2]), .first_fail_idx(ff_w[2]));
    gate_bist #(.WIDTH(4), .NUM_VECTORS(70000), .LATENCY(0), .SEED(SEED)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[3]), .op_sel(op_s[3]), .gif(bif3.master),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]),
        .err_count(err_w[3]), .vec_count(vec_w[3]), .first_fail_idx(ff_w[3]));

    assign sa[0] = {7'b0, bif0.stim_a};
    assign sb[0] = {7'b0, bif0.stim_b};
    assign sa[1] = bif1.stim_a;
    assign sb[1] = bif1.stim_b;
    assign sa[2] = bif2.stim_a;
    assign sb[2] = bif2.stim_b;
    assign sa[3] = {4'b0, bif3.stim_a};
    assign sb[3] = {4'b0, bif3.stim_b};

    // gates under test
    always_ff @(posedge clk) begin
        r1_1 <= ~(bif1.stim_a | bif1.stim_b);
        r2_1 <= r1_1;
        r1_2 <= ~(bif2.stim_a | bif2.stim_b);
        r2_2 <= r1_2;
    end
    assign bif0.dut_x = ~(bif0.stim_a & bif0.stim_b);
    assign bif1.dut_x = (u1_mode == M_XOR1) ? (bif1.stim_a ^ bif1.stim_b ^ 8'h01) :
                        (u1_mode == M_REG2) ? r2_1 : ~(bif1.stim_a ^ bif1.stim_b);
    assign bif2.dut_x = r2_2;
    assign bif3.dut_x = 4'hF;

    typedef struct {
        int u; int w; int n; int lat; int op; int mode; int poke;
        int err_e; int first_e;
    } test_t;

    typedef struct { int err; int first; int vec; int pass; } exp_t;

    exp_t        exp_q  [$];
    logic [15:0] stim_q [$];
    test_t       tests  [6];

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [7:0] fn(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return ~(a & b);
            3: return ~(a | b);
            4: return a ^ b;
            5: return ~(a ^ b);
            6: return a;
            default: return ~a;
        endcase
    endfunction

    // Expected error count and first failing index from the bench's own vector sequence
    task automatic model(input int w, input int n, input int lat, input int op, input int mode,
                         output int err, output int first);
        logic [7:0]  av [];
        logic [7:0]  bv [];
        logic [31:0] l = SEED;
        logic [7:0]  m = 8'((1 << w) - 1);
        logic [7:0]  e, d;
        int          j;
        av = new[n];
        bv = new[n];
        for (int k = 0; k < n; k++) begin
            av[k] = l[7:0] & m;
            bv[k] = l[23:16] & m;
            l = lfsr_next(l);
        end
        err = 0;
        first = -1;
        for (int k = 0; k < n; k++) begin
            e = fn(op, av[k], bv[k]) & m;
            case (mode)
                M_NAND:  d = ~(av[k] & bv[k]) & m;
                M_XOR1:  d = (av[k] ^ bv[k] ^ 8'h01) & m;
                M_REG2: begin
                    j = k - 2 + lat;
                    d = (j >= 0 && j < n) ? (~(av[j] | bv[j]) & m) : m;
                end
                M_XNOR:  d = ~(av[k] ^ bv[k]) & m;
                default: d = 8'hFF & m;
            endcase
            if (d != e) begin
                if (err < 65535) err++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic run(input test_t t);
        logic [31:0] l = SEED;
        logic [7:0]  m = 8'((1 << t.w) - 1);
        logic [15:0] s;
        exp_t        x;
        int          edges;
        repeat (3) @(posedge clk);
        #1;
        stim_q.delete();
        for (int k = 0; k < t.n && k < 32; k++) begin
            stim_q.push_back({l[7:0] & m, l[23:16] & m});
            l = lfsr_next(l);
        end
        exp_q.push_back('{t.err_e, t.first_e, t.n, (t.err_e == 0) ? 1 : 0});
        if (t.u == 1) u1_mode = t.mode;
        op_s[t.u]    = 3'(t.op);
        start_s[t.u] = 1'b1;
        @(posedge clk);
        #1;
        start_s[t.u] = 1'b0;
        chk("done_at_start", done_w[t.u], 0);
        chk("pass_at_start", pass_w[t.u], 0);
        edges = 0;
        while (!done_w[t.u] && edges < t.n + t.lat + 10) begin
            if (edges < 8) chk("busy_run", busy_w[t.u], 1);
            if (stim_q.size() > 0 && edges < t.n) begin
                s = stim_q.pop_front();
                chk("stim_a", sa[t.u], s[15:8]);
                chk("stim_b", sb[t.u], s[7:0]);
            end
            if (edges == t.poke) begin
                start_s[t.u] = 1'b1;
                op_s[t.u]    = 3'(t.op ^ 1);
            end else if (edges == t.poke + 1) begin
                start_s[t.u] = 1'b0;
                op_s[t.u]    = 3'(t.op);
            end
            @(posedge clk);
            #1;
            edges++;
        end
        chk("done_edge", edges, t.n + t.lat);
        x = exp_q.pop_front();
        chk("err_count", err_w[t.u], x.err);
        chk("vec_count", vec_w[t.u], x.vec);
        chk("pass", pass_w[t.u], x.pass);
        chk("busy_done", busy_w[t.u], 0);
        if (x.err != 0) chk("first_fail_idx", ff_w[t.u], x.first);
        chk("stim_idle", {sa[t.u], sb[t.u]}, 0);
    endtask

    task automatic check_zero(input int u, input string tag);
        chk({tag, "_busy"}, busy_w[u], 0);
        chk({tag, "_done"}, done_w[u], 0);
        chk({tag, "_pass"}, pass_w[u], 0);
        chk({tag, "_err"},  err_w[u], 0);
        chk({tag, "_vec"},  vec_w[u], 0);
        chk({tag, "_ff"},   ff_w[u], 0);
        chk({tag, "_stim"}, {sa[u], sb[u]}, 0);
    endtask

    initial begin
        logic [31:0] l;
        logic [15:0] s;
        int          e, f;

        //          u  w  n      lat op mode    poke
        tests[0] = '{0, 1, 20,    0, 2, M_NAND, -1, 0, 0};
        tests[1] = '{0, 1, 20,    0, 2, M_NAND,  5, 0, 0};
        tests[2] = '{1, 8, 20,    0, 4, M_XOR1, -1, 0, 0};
        tests[3] = '{2, 8, 20,    2, 3, M_REG2, -1, 0, 0};
        tests[4] = '{1, 8, 20,    0, 3, M_REG2, -1, 0, 0};
        tests[5] = '{3, 4, 70000, 0, 0, M_TIEF, -1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            model(tests[i].w, tests[i].n, tests[i].lat, tests[i].op, tests[i].mode, e, f);
            tests[i].err_e   = e;
            tests[i].first_e = f;
        end

        rst_n   = 1'b0;
        start_s = 4'b0;
        for (int i = 0; i < 4; i++) op_s[i] = 3'd0;
        #1;
        for (int i = 0; i < 4; i++) check_zero(i, "reset");
        #30;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run(tests[i]);

        // abort mid-run with reset, then a rerun must replay vector 0 onward
        repeat (3) @(posedge clk);
        #1;
        u1_mode    = M_XNOR;
        op_s[1]    = 3'd5;
        start_s[1] = 1'b1;
        @(posedge clk);
        #1;
        start_s[1] = 1'b0;
        l = SEED;
        for (int k = 0; k <= 7; k++) begin
            s = {l[7:0], l[23:16]};
            chk("pre_reset_stim", {sa[1], sb[1]}, s);
            l = lfsr_next(l);
            if (k < 7) begin
                @(posedge clk);
                #1;
            end
        end
        chk("pre_reset_vec", vec_w[1], 7);
        chk("pre_reset_busy", busy_w[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(1, "mid_reset");
        #20;
        rst_n = 1'b1;
        model(8, 20, 0, 5, M_XNOR, e, f);
        run('{1, 8, 20, 0, 5, M_XNOR, -1, e, f});

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
